// File: rtl/ttl_jkff_bank_edge_if.sv
// Signal bundle for the ttl_jkff_bank_edge J-K flip-flop bank.
// The master side drives the TTL-style inputs, and the slave side (the bank) returns Q/Qn/Ev.
interface ttl_jkff_bank_edge_if #(
  parameter int BLOCKS = 2
);
  logic [BLOCKS-1:0] cen;
  logic [BLOCKS-1:0] clr_n;
  logic [BLOCKS-1:0] pre_n;
  logic [BLOCKS-1:0] j;
  logic [BLOCKS-1:0] k;
  logic [BLOCKS-1:0] q;
  logic [BLOCKS-1:0] qn;
  logic [BLOCKS-1:0] ev;

  modport master (output cen, clr_n, pre_n, j, k, input q, qn, ev);
  modport slave  (input cen, clr_n, pre_n, j, k, output q, qn, ev);
endinterface

// File: rtl/ttl_jkff_bank_edge.sv
// Bank of BLOCKS edge-detected 74LS76/107/109-style J-K flip-flops, all clocked by clk_i.
// The optional macro JKFF_CASCADE_EN chains the stages as a ripple counter: stage i>0 is clocked by the falling edge of Q[i-1].
module ttl_jkff_bank_edge #(
  parameter int                BLOCKS   = 2,
  parameter int                CEN_EDGE = 0,
  parameter logic [BLOCKS-1:0] INIT_Q   = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  ttl_jkff_bank_edge_if.slave  bus
);

`ifdef JKFF_CASCADE_EN
  localparam bit CASCADE = 1'b1;
`else
  localparam bit CASCADE = 1'b0;
`endif

  localparam logic [BLOCKS-1:0] ONE       = BLOCKS'(1);
  localparam logic [BLOCKS-1:0] CEN_RISE  = (CEN_EDGE != 0) ? '1 : '0;
  localparam logic [BLOCKS-1:0] RISE_MASK = CASCADE ? (CEN_RISE & ONE) : CEN_RISE;
  // Cascaded stages track the previous Q, so their edge history starts at that stage's INIT_Q.
  localparam logic [BLOCKS-1:0] LAST_RST  =
      CASCADE ? (((INIT_Q << 1) & ~ONE) | (CEN_RISE & ONE)) : CEN_RISE;

  logic [BLOCKS-1:0] q_q, q_d;
  logic [BLOCKS-1:0] qn_q, qn_d;
  logic [BLOCKS-1:0] ev_q, ev_d;
  logic [BLOCKS-1:0] last_q;
  logic [BLOCKS-1:0] src_w;
  logic [BLOCKS-1:0] edge_w;

  assign src_w  = CASCADE ? (((q_q << 1) & ~ONE) | (bus.cen & ONE)) : bus.cen;
  assign edge_w = (src_w & ~last_q & RISE_MASK) | (~src_w & last_q & ~RISE_MASK);

  always_comb begin
    q_d  = q_q;
    qn_d = qn_q;
    ev_d = '0;
    for (int i = 0; i < BLOCKS; i++) begin
      if (!bus.clr_n[i] && !bus.pre_n[i]) begin
        q_d[i]  = 1'b1;
        qn_d[i] = 1'b1;
      end else if (!bus.clr_n[i]) begin
        q_d[i]  = 1'b0;
        qn_d[i] = 1'b1;
      end else if (!bus.pre_n[i]) begin
        q_d[i]  = 1'b1;
        qn_d[i] = 1'b0;
      end else begin
        if (edge_w[i]) begin
          ev_d[i] = 1'b1;
          case ({bus.j[i], bus.k[i]})
            2'b01:   q_d[i] = 1'b0;
            2'b10:   q_d[i] = 1'b1;
            2'b11:   q_d[i] = ~q_q[i];
            default: q_d[i] = q_q[i];
          endcase
        end
        // Releasing clear/preset restores Qn = ~Q, including after the both-low state.
        qn_d[i] = ~q_d[i];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      q_q    <= INIT_Q;
      qn_q   <= ~INIT_Q;
      ev_q   <= '0;
      last_q <= LAST_RST;
    end else begin
      q_q    <= q_d;
      qn_q   <= qn_d;
      ev_q   <= ev_d;
      last_q <= src_w;
    end
  end

  assign bus.q  = q_q;
  assign bus.qn = qn_q;
  assign bus.ev = ev_q;

endmodule
